// File: rtl/sklansky_adder_16.sv
// ---------------------------------------------------------------------------
// sklansky_adder_16
//   Registered Sklansky (divide-and-conquer) parallel-prefix adder.
//   Computes {cout, sum} = a + b + cin. The result is registered, so the unit
//   can sit directly in a datapath pipeline.
//
//   The carry-in is folded into bit 0's generate before the tree. Each of the
//   log2(WIDTH) prefix levels then merges the upper half of every 2^(k+1)
//   block with the top bit of that block's lower half. After the last level,
//   g[i] is the group generate over bits i..0 including cin. That value is
//   the carry into bit i+1.
//
//   Optional build macro:
//     SKLANSKY_PIPE_EN  adds a register stage after prefix level log2(WIDTH)/2.
//                       The stage holds the group G/P vectors, the bit
//                       propagates and cin. Latency becomes 2 and throughput
//                       stays one result per cycle. With the macro undefined
//                       there is a single output register and latency 1.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      a/b/cin valid this cycle
//   a, b       in   WIDTH  unsigned operands
//   cin        in   1      carry-in
//   out_valid  out  1      sum/cout hold a fresh result
//   sum        out  WIDTH  (a+b+cin) mod 2^WIDTH, held while no new result
//   cout       out  1      carry out of bit WIDTH-1, held like sum
// ---------------------------------------------------------------------------
module sklansky_adder_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int MID    = LEVELS / 2;

    // Bit-level generate/propagate; cin is absorbed as a generate below bit 0.
    logic [WIDTH-1:0] g_bit;
    logic [WIDTH-1:0] p_bit;
    logic [WIDTH-1:0] g_lvl0;

    assign g_bit = a & b;
    assign p_bit = a ^ b;

    always_comb begin
        g_lvl0    = g_bit;
        g_lvl0[0] = g_bit[0] | (p_bit[0] & cin);
    end

`ifdef SKLANSKY_PIPE_EN
    // Mid-tree register stage.
    logic [WIDTH-1:0] mid_g_d;
    logic [WIDTH-1:0] mid_p_d;
    logic [WIDTH-1:0] mid_g_q;
    logic [WIDTH-1:0] mid_p_q;
    logic [WIDTH-1:0] p_bit_q;
    logic             cin_q;
    logic             valid_mid_q;
`endif

    // Prefix tree. Each level is a named block so that the next level can
    // read the previous level's outputs.
    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        logic [WIDTH-1:0] g_in;
        logic [WIDTH-1:0] p_in;
        logic [WIDTH-1:0] g_o;
        logic [WIDTH-1:0] p_o;

`ifdef SKLANSKY_PIPE_EN
        if (k == MID) begin : g_src_reg
            assign g_in = mid_g_q;
            assign p_in = mid_p_q;
        end else
`endif
        if (k == 0) begin : g_src_bit
            assign g_in = g_lvl0;
            assign p_in = p_bit;
        end else begin : g_src_prev
            assign g_in = g_level[k-1].g_o;
            assign p_in = g_level[k-1].p_o;
        end

        always_comb begin
            int j;
            j   = 0;
            g_o = g_in;
            p_o = p_in;
            for (int i = 0; i < WIDTH; i++) begin
                // Bit k of the index set means the bit is in the upper half of
                // its 2^(k+1) block. j is the top bit of the lower half.
                if (((i >> k) & 1) != 0) begin
                    j      = (i & ~((1 << (k + 1)) - 1)) | ((1 << k) - 1);
                    g_o[i] = g_in[i] | (p_in[i] & g_in[j]);
                    p_o[i] = p_in[i] & p_in[j];
                end
            end
        end
    end

`ifdef SKLANSKY_PIPE_EN
    if (MID == 0) begin : g_mid_from_bit
        assign mid_g_d = g_lvl0;
        assign mid_p_d = p_bit;
    end else begin : g_mid_from_tree
        assign mid_g_d = g_level[MID-1].g_o;
        assign mid_p_d = g_level[MID-1].p_o;
    end

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_mid_q <= 1'b0;
            mid_g_q     <= '0;
            mid_p_q     <= '0;
            p_bit_q     <= '0;
            cin_q       <= 1'b0;
        end else begin
            valid_mid_q <= in_valid;
            if (in_valid) begin
                mid_g_q <= mid_g_d;
                mid_p_q <= mid_p_d;
                p_bit_q <= p_bit;
                cin_q   <= cin;
            end
        end
    end
`endif

    // Sum stage sources, taken from the pipeline register when it exists.
    logic [WIDTH-1:0] p_sum;
    logic             cin_sum;
    logic             valid_sum;

`ifdef SKLANSKY_PIPE_EN
    assign p_sum     = p_bit_q;
    assign cin_sum   = cin_q;
    assign valid_sum = valid_mid_q;
`else
    assign p_sum     = p_bit;
    assign cin_sum   = cin;
    assign valid_sum = in_valid;
`endif

    logic [WIDTH-1:0] g_fin;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             out_valid_q;

    assign g_fin  = g_level[LEVELS-1].g_o;
    // Carry into bit i is the prefix generate of bit i-1. The carry into
    // bit 0 is cin itself.
    assign sum_d  = p_sum ^ {g_fin[WIDTH-2:0], cin_sum};
    assign cout_d = g_fin[WIDTH-1];

    // Group propagates of the final level feed nothing downstream.
    logic unused_p_top;
    assign unused_p_top = ^g_level[LEVELS-1].p_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
        end else begin
            out_valid_q <= valid_sum;
            // NOTE: the result is loaded only on valid. An invalid cycle
            // therefore holds the last result, and X operands never reach it.
            if (valid_sum) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_sklansky_adder_16.sv
// ---------------------------------------------------------------------------
// tb_sklansky_adder_16
//   Self-checking bench for sklansky_adder_16.
//   The reference model is plain arithmetic ({cout,sum} = a + b + cin). Each
//   result is pushed into a queue of results in flight, whose depth equals the
//   adder latency. A result that leaves the queue valid becomes the expected
//   held output.
//   Build with SKLANSKY_PIPE_EN defined to exercise the 2-cycle variant.
// ---------------------------------------------------------------------------
module tb_sklansky_adder_16;

    localparam int W = 16;
`ifdef SKLANSKY_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;

    always #5 clk = ~clk;

    sklansky_adder_16 #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .sum      (sum),
        .cout     (cout)
    );

    typedef struct packed {
        logic       v;
        logic [W:0] r;
    } ent_t;

    ent_t       inflight[$];
    logic       exp_valid;
    logic [W:0] exp_held;
    int         checks = 0;
    int         errors = 0;

    task automatic model_reset();
        ent_t idle;
        idle = '0;
        inflight.delete();
        for (int i = 0; i < LAT - 1; i++) inflight.push_back(idle);
        exp_valid = 1'b0;
        exp_held  = '0;
    endtask

    // Advance one clock. The model samples the inputs at the edge, like the
    // DUT does. Returns 1 ns after the edge, ready for sampling.
    task automatic step();
        ent_t e;
        ent_t done;
        @(posedge clk);
        e.v = in_valid;
        e.r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        if (!rst_n) begin
            model_reset();
        end else begin
            inflight.push_back(e);
            done = inflight.pop_front();
            exp_valid = done.v;
            if (done.v) exp_held = done.r;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 16'hFFFF;
        b        = 16'h0001;
        cin      = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            checks++;
            if (out_valid !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d]: out_valid=%0b sum=%h cout=%0b, expected 0/0000/0",
                         i, out_valid, sum, cout);
            end
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[4];
        logic [W-1:0] tb_[4];
        logic         tc[4];
        logic [W-1:0] ts[4];
        logic         tco[4];
        ta  = '{16'd15, 16'd269,  16'hFFFF, 16'h8000};
        tb_ = '{16'd8,  16'd4170, 16'h0000, 16'h8000};
        tc  = '{1'b0,   1'b0,     1'b1,     1'b1};
        ts  = '{16'd23, 16'd4439, 16'h0000, 16'h0001};
        tco = '{1'b0,   1'b0,     1'b1,     1'b1};
        for (int t = 0; t < 4; t++) begin
            a = ta[t]; b = tb_[t]; cin = tc[t]; in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            a = 'x; b = 'x; cin = 'x;
            for (int i = 0; i < LAT - 1; i++) step();
            checks++;
            if (out_valid !== 1'b1 || sum !== ts[t] || cout !== tco[t]) begin
                errors++;
                $display("FAIL directed[%0d]: out_valid=%0b sum=%h cout=%0b, expected 1/%h/%0b",
                         t, out_valid, sum, cout, ts[t], tco[t]);
            end
            // Invalid cycle with X operands: valid drops, result held.
            step();
            checks++;
            if (out_valid !== 1'b0 || sum !== ts[t] || cout !== tco[t]) begin
                errors++;
                $display("FAIL hold[%0d]: out_valid=%0b sum=%h cout=%0b, expected 0/%h/%0b",
                         t, out_valid, sum, cout, ts[t], tco[t]);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 1300; n++) begin
            // After 1000 valid cycles, mix in bubbles with X operands.
            in_valid = (n < 1000) ? 1'b1 : ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       a = 16'hFFFF;
                1:       a = 16'h0000;
                default: a = W'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       b = 16'hFFFF;
                1:       b = 16'h0000;
                default: b = W'($urandom);
            endcase
            cin = 1'($urandom);
            if (!in_valid) begin
                a = 'x; b = 'x; cin = 'x;
            end
            step();
            checks++;
            if (out_valid !== exp_valid || sum !== exp_held[W-1:0] || cout !== exp_held[W]) begin
                errors++;
                $display("FAIL random[%0d]: out_valid=%0b sum=%h cout=%0b, expected %0b/%h/%0b",
                         n, out_valid, sum, cout, exp_valid, exp_held[W-1:0], exp_held[W]);
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < LAT; i++) step();
    endtask

    task automatic test_reset_mid();
        a = 16'h1234; b = 16'h4321; cin = 1'b1; in_valid = 1'b1;
        step();
        a = 16'hFFFF; b = 16'hFFFF;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: out_valid=%0b sum=%h cout=%0b, expected 0/0000/0",
                     out_valid, sum, cout);
        end
        step();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_flush: out_valid=%0b sum=%h cout=%0b, expected 0/0000/0",
                     out_valid, sum, cout);
        end
        // Recovery after reset: one fresh vector must come through intact.
        a = 16'h7FFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            if (i > 0) step();
        end
        checks++;
        if (out_valid !== 1'b1 || sum !== 16'h8000 || cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_recover: out_valid=%0b sum=%h cout=%0b, expected 1/8000/0",
                     out_valid, sum, cout);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
